// File: rtl/ca_seq_pkg.sv
// Shared types and constants for the Rule 110 array sequencer.
package ca_seq_pkg;

  localparam int unsigned CELLS_PER_BLOCK = 8;
  localparam int unsigned ADDR_W          = 6;

  typedef enum logic [1:0] {
    OP_RUN  = 2'd0,
    OP_LOAD = 2'd1,
    OP_DUMP = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_LOAD_WR   = 3'd3,
    S_DUMP_ADDR = 3'd4,
    S_DUMP_OUT  = 3'd5
  } state_e;

endpackage

// File: rtl/ca_seq_blk_counter.sv
// Block index counter shared by the LOAD and DUMP walks over the array.
module ca_seq_blk_counter
  import ca_seq_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);

  logic [ADDR_W-1:0] idx_r;

  // Clear wins over increment so every walk starts at block 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= {ADDR_W{1'b0}};
    end else if (clr) begin
      idx_r <= {ADDR_W{1'b0}};
    end else if (inc) begin
      idx_r <= idx_r + ADDR_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  assign idx  = idx_r;
  assign last = (idx_r == LAST_IDX);

endmodule

// File: rtl/ca_sequencer.sv
// Command sequencer for the Rule 110 cell array (RUN / LOAD / DUMP).
// Optional CA_SEQ_AUTODUMP_EN: a RUN flows straight into a full DUMP.
module ca_sequencer
  import ca_seq_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 30,
  parameter int unsigned GEN_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [GEN_W-1:0]           cmd_arg,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [CELLS_PER_BLOCK-1:0] load_data,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [CELLS_PER_BLOCK-1:0] dump_data,
  output logic                       dump_last,
  output logic                       ca_we_n,
  output logic                       ca_halt_n,
  output logic [ADDR_W-1:0]          ca_addr,
  output logic [CELLS_PER_BLOCK-1:0] ca_wdata,
  input  logic [CELLS_PER_BLOCK-1:0] ca_rdata,
  output logic                       busy,
  output logic [GEN_W-1:0]           gen_count
);

  state_e                     state_r;
  logic [GEN_W-1:0]           run_cnt_r;
  logic [GEN_W-1:0]           gen_count_r;
  logic                       ca_we_n_r;
  logic                       ca_halt_n_r;
  logic [ADDR_W-1:0]          ca_addr_r;
  logic [CELLS_PER_BLOCK-1:0] ca_wdata_r;
  logic                       load_ready_r;
  logic                       dump_valid_r;
  logic                       dump_last_r;
  logic [CELLS_PER_BLOCK-1:0] dump_data_r;

  logic              blk_clr_s;
  logic              blk_inc_s;
  logic              blk_last_s;
  logic [ADDR_W-1:0] blk_idx_s;
  op_e               op_s;
  logic              load_fire_s;
  logic              dump_fire_s;

  assign op_s        = op_e'(cmd_op);
  assign load_fire_s = load_valid && load_ready_r;
  assign dump_fire_s = dump_valid_r && dump_ready;

  ca_seq_blk_counter #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_blk_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (blk_clr_s),
    .inc   (blk_inc_s),
    .idx   (blk_idx_s),
    .last  (blk_last_s)
  );

  // Block counter control: parked at 0 outside the walks, stepped after each block.
  always_comb begin
    blk_clr_s = 1'b0;
    blk_inc_s = 1'b0;
    case (state_r)
      S_IDLE:     blk_clr_s = 1'b1;
      S_RUN:      blk_clr_s = 1'b1;
      S_LOAD_WR:  blk_inc_s = !blk_last_s;
      S_DUMP_OUT: blk_inc_s = dump_fire_s && !blk_last_s;
      default: begin
        blk_clr_s = 1'b0;
        blk_inc_s = 1'b0;
      end
    endcase
  end

  // Main FSM; all array pins and stream flags are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      run_cnt_r    <= {GEN_W{1'b0}};
      gen_count_r  <= {GEN_W{1'b0}};
      ca_we_n_r    <= 1'b1;
      ca_halt_n_r  <= 1'b0;
      ca_addr_r    <= {ADDR_W{1'b0}};
      ca_wdata_r   <= {CELLS_PER_BLOCK{1'b0}};
      load_ready_r <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_last_r  <= 1'b0;
      dump_data_r  <= {CELLS_PER_BLOCK{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          ca_halt_n_r <= 1'b0;
          ca_we_n_r   <= 1'b1;
          if (cmd_valid) begin
            case (op_s)
              OP_RUN: begin
                if (cmd_arg != {GEN_W{1'b0}}) begin
                  state_r     <= S_RUN;
                  ca_halt_n_r <= 1'b1;
                  run_cnt_r   <= cmd_arg;
                end else begin
                  state_r <= S_IDLE;
                end
              end
              OP_LOAD: begin
                state_r      <= S_LOAD_WAIT;
                ca_addr_r    <= {ADDR_W{1'b0}};
                load_ready_r <= 1'b1;
              end
              OP_DUMP: begin
                state_r   <= S_DUMP_ADDR;
                ca_addr_r <= {ADDR_W{1'b0}};
              end
              default: state_r <= S_IDLE;
            endcase
          end
        end
        // Each cycle spent here with halt released is one generation.
        S_RUN: begin
          gen_count_r <= gen_count_r + GEN_W'(1);
          if (run_cnt_r == GEN_W'(1)) begin
            ca_halt_n_r <= 1'b0;
`ifdef CA_SEQ_AUTODUMP_EN
            state_r   <= S_DUMP_ADDR;
            ca_addr_r <= {ADDR_W{1'b0}};
`else
            state_r <= S_IDLE;
`endif
          end else begin
            run_cnt_r <= run_cnt_r - GEN_W'(1);
          end
        end
        S_LOAD_WAIT: begin
          if (load_fire_s) begin
            ca_we_n_r    <= 1'b0;
            ca_wdata_r   <= load_data;
            load_ready_r <= 1'b0;
            state_r      <= S_LOAD_WR;
          end
        end
        S_LOAD_WR: begin
          ca_we_n_r <= 1'b1;
          if (blk_last_s) begin
            state_r <= S_IDLE;
          end else begin
            ca_addr_r    <= blk_idx_s + ADDR_W'(1);
            load_ready_r <= 1'b1;
            state_r      <= S_LOAD_WAIT;
          end
        end
        // The read port is combinational in ca_addr, so it is valid one cycle after issue.
        S_DUMP_ADDR: begin
          dump_data_r  <= ca_rdata;
          dump_valid_r <= 1'b1;
          dump_last_r  <= blk_last_s;
          state_r      <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (dump_fire_s) begin
            dump_valid_r <= 1'b0;
            dump_last_r  <= 1'b0;
            if (blk_last_s) begin
              state_r <= S_IDLE;
            end else begin
              ca_addr_r <= blk_idx_s + ADDR_W'(1);
              state_r   <= S_DUMP_ADDR;
            end
          end
        end
        default: begin
          state_r      <= S_IDLE;
          ca_we_n_r    <= 1'b1;
          ca_halt_n_r  <= 1'b0;
          load_ready_r <= 1'b0;
          dump_valid_r <= 1'b0;
          dump_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_r == S_IDLE);
  assign busy       = (state_r != S_IDLE);
  assign gen_count  = gen_count_r;
  assign ca_we_n    = ca_we_n_r;
  assign ca_halt_n  = ca_halt_n_r;
  assign ca_addr    = ca_addr_r;
  assign ca_wdata   = ca_wdata_r;
  assign load_ready = load_ready_r;
  assign dump_valid = dump_valid_r;
  assign dump_last  = dump_last_r;
  assign dump_data  = dump_data_r;

endmodule

// File: tb/tb_ca_sequencer.sv
// Scoreboard bench for ca_sequencer driving a behavioural Rule 110 array.
module tb_ca_sequencer;
  import ca_seq_pkg::*;

  localparam int NB = 30;
  localparam int GW = 16;
  localparam int NC = NB * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [GW-1:0] cmd_arg;
  logic          load_valid;
  logic          load_ready;
  logic [7:0]    load_data;
  logic          dump_valid;
  logic          dump_ready;
  logic [7:0]    dump_data;
  logic          dump_last;
  logic          ca_we_n;
  logic          ca_halt_n;
  logic [5:0]    ca_addr;
  logic [7:0]    ca_wdata;
  logic [7:0]    ca_rdata;
  logic          busy;
  logic [GW-1:0] gen_count;

  always #5 clk = ~clk;

  ca_sequencer #(.NUM_BLOCKS(NB), .GEN_W(GW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
    .ca_we_n(ca_we_n), .ca_halt_n(ca_halt_n), .ca_addr(ca_addr),
    .ca_wdata(ca_wdata), .ca_rdata(ca_rdata), .busy(busy), .gen_count(gen_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Rule 110 with wrap-around; left neighbour of cell i is i-1.
  function automatic logic [NC-1:0] rule110_step(input logic [NC-1:0] s);
    logic [NC-1:0] n;
    logic [7:0]    rule;
    logic [2:0]    p;
    rule = 8'd110;
    for (int i = 0; i < NC; i++) begin
      p    = {s[(i + NC - 1) % NC], s[i], s[(i + 1) % NC]};
      n[i] = rule[p];
    end
    return n;
  endfunction

  // Behavioural array: write has priority, halt_n advances, read shows T+1.
  logic [NC-1:0] arr = '0;
  logic [NC-1:0] arr_next;
  always_comb arr_next = rule110_step(arr);
  always_comb begin
    ca_rdata = 8'h00;
    if (int'(ca_addr) < NB) ca_rdata = arr_next[int'(ca_addr) * 8 +: 8];
  end
  always @(posedge clk) begin
    if (!ca_we_n) begin
      if (int'(ca_addr) < NB) arr[int'(ca_addr) * 8 +: 8] <= ca_wdata;
    end else if (ca_halt_n) begin
      arr <= rule110_step(arr);
    end
  end

  logic [13:0]   load_q[$];
  logic [9:0]    dump_q[$];
  logic [NC-1:0] ref_s = '0;
  int   we_pulses = 0, halt_cycles = 0, excl_viol = 0, we_long_viol = 0, ready_in_window = 0;
  logic prev_we_n = 1'b1, prev_stall = 1'b0, watch_idle = 1'b0;
  logic [8:0] prev_dump = 9'd0;
  logic [7:0] dump_first = 8'd0;

  // Monitor: sample on the falling edge, pop the scoreboard on each output event.
  initial begin : monitor
    logic [13:0] e;
    logic [9:0]  d;
    forever begin
      @(negedge clk);
      if (ca_halt_n === 1'b1) halt_cycles++;
      if (!ca_we_n && ca_halt_n) excl_viol++;
      if (!ca_we_n && !prev_we_n) we_long_viol++;
      if (watch_idle && cmd_ready) ready_in_window++;
      if (ca_we_n === 1'b0) begin
        we_pulses++;
        if (load_q.size() == 0) check_eq("we_unexpected", load_q.size(), 1);
        else begin
          e = load_q.pop_front();
          check_eq("we_addr", ca_addr, e[13:8]);
          check_eq("we_data", ca_wdata, e[7:0]);
        end
      end
      if (dump_valid && prev_stall) check_eq("dump_stable", {dump_last, dump_data}, prev_dump);
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) check_eq("dump_unexpected", dump_q.size(), 1);
        else begin
          d = dump_q.pop_front();
          if (d[9]) dump_first = dump_data;
          check_eq("dump_data", dump_data, d[7:0]);
          check_eq("dump_last", dump_last, d[8]);
        end
      end
      prev_stall = dump_valid && !dump_ready;
      prev_dump  = {dump_last, dump_data};
      prev_we_n  = ca_we_n;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [GW-1:0] arg);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
    if (!cmd_ready) check_eq("cmd_ready_timeout", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    do begin @(negedge clk); cycles++; end while (!cmd_ready && cycles < 2000);
    if (!cmd_ready) check_eq({tag, "_timeout"}, cmd_ready, 1);
  endtask

  // mode 0: byte k = k; mode 1: only cell 1 set.
  task automatic do_load(input int mode, input int stall_at, input int reset_at);
    logic [7:0] b;
    int t;
    send_cmd(OP_LOAD, '0);
    for (int k = 0; k < NB; k++) begin
      b = (mode == 0) ? 8'(k) : ((k == 0) ? 8'h02 : 8'h00);
      if (k == stall_at) repeat (3) @(negedge clk);
      @(negedge clk);
      load_valid = 1'b1; load_data = b;
      t = 0;
      while (!load_ready && t < 50) begin @(negedge clk); t++; end
      if (!load_ready) begin
        check_eq("load_ready_timeout", load_ready, 1);
        load_valid = 1'b0;
        return;
      end
      if (k == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; load_valid = 1'b0;
        return;
      end
      load_q.push_back({6'(k), b});
      ref_s[k * 8 +: 8] = b;
      @(posedge clk); #1;
      load_valid = 1'b0;
    end
  endtask

  task automatic push_dump(input logic [NC-1:0] exp_s);
    for (int k = 0; k < NB; k++) dump_q.push_back({k == 0, k == NB - 1, exp_s[k * 8 +: 8]});
  endtask

  task automatic drain_dump();
    int t = 0;
    while ((dump_q.size() != 0 || !cmd_ready) && t < 1000) begin
      @(posedge clk); #1;
      dump_ready = (t % 3 != 2);
      t++;
    end
    dump_ready = 1'b0;
    check_eq("dump_q_empty", dump_q.size(), 0);
  endtask

  int cyc, h0, p0;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
    load_valid = 1'b0; load_data = 8'h00; dump_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_halt_n", ca_halt_n, 0);
    check_eq("rst_we_n", ca_we_n, 1);
    check_eq("rst_addr", ca_addr, 0);
    check_eq("rst_wdata", ca_wdata, 0);
    check_eq("rst_dump_valid", dump_valid, 0);
    check_eq("rst_dump_last", dump_last, 0);
    check_eq("rst_load_ready", load_ready, 0);
    check_eq("rst_gen_count", gen_count, 0);
    reset = 1'b0;

`ifndef CA_SEQ_AUTODUMP_EN
    h0 = halt_cycles;
    send_cmd(OP_RUN, 16'd5);
    wait_idle("run5", cyc);
    check_eq("run5_cycles", cyc, 6);
    check_eq("run5_halt_cycles", halt_cycles - h0, 5);
    check_eq("run5_gen_count", gen_count, 5);
    for (int i = 0; i < 5; i++) ref_s = rule110_step(ref_s);

    h0 = halt_cycles;
    send_cmd(OP_RUN, 16'd0);
    wait_idle("run0", cyc);
    check_eq("run0_cycles", cyc, 1);
    check_eq("run0_halt_cycles", halt_cycles - h0, 0);
    check_eq("run0_gen_count", gen_count, 5);
`endif

    send_cmd(OP_RSVD, 16'd7);
    wait_idle("rsvd", cyc);
    check_eq("rsvd_cycles", cyc, 1);

    h0 = halt_cycles; p0 = we_pulses;
    do_load(0, 4, -1);
    wait_idle("load", cyc);
    check_eq("load_pulses", we_pulses - p0, NB);
    check_eq("load_halt_cycles", halt_cycles - h0, 0);
    check_eq("load_q_empty", load_q.size(), 0);

    p0 = we_pulses;
    do_load(0, -1, 9);
    @(negedge clk);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_we_n", ca_we_n, 1);
    check_eq("midrst_load_ready", load_ready, 0);
    check_eq("midrst_halt_n", ca_halt_n, 0);
    check_eq("midrst_pulses", we_pulses - p0, 9);
    check_eq("midrst_q_empty", load_q.size(), 0);

    do_load(1, -1, -1);
    wait_idle("load1", cyc);
    h0 = halt_cycles;
    push_dump(rule110_step(ref_s));
    send_cmd(OP_DUMP, '0);
    drain_dump();
    check_eq("dump_byte0", dump_first, 8'h03);
    check_eq("dump_halt_cycles", halt_cycles - h0, 0);

`ifdef CA_SEQ_AUTODUMP_EN
    h0 = halt_cycles;
    ref_s = rule110_step(ref_s);
    push_dump(rule110_step(ref_s));
    send_cmd(OP_RUN, 16'd1);
    watch_idle = 1'b1;
    drain_dump();
    watch_idle = 1'b0;
    check_eq("autodump_no_idle", ready_in_window, 0);
    check_eq("autodump_halt_cycles", halt_cycles - h0, 1);
    check_eq("autodump_gen_count", gen_count, 1);
`endif

    repeat (2) @(negedge clk);
    check_eq("we_halt_exclusive", excl_viol, 0);
    check_eq("we_single_cycle", we_long_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
